// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
// parity_pkg : shared parity convention for encoder and downstream checker
// Rev 1.0
// ============================================================================
package parity_pkg;

  localparam int c_MAX_W = 64;

  localparam bit c_EVEN = 1'b0;
  localparam bit c_ODD  = 1'b1;
  localparam bit c_LSB  = 1'b0;
  localparam bit c_MSB  = 1'b1;

  // Zero-padding the payload to c_MAX_W leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [c_MAX_W-1:0] data, input logic even_odd);
    return (^data) ^ even_odd;
  endfunction

  function automatic logic [c_MAX_W:0] assemble_word(input logic [c_MAX_W-1:0] payload,
                                                      input logic              p,
                                                      input logic              parity_bit,
                                                      input int unsigned       width);
    logic [c_MAX_W:0] w_word;
    if (parity_bit == c_LSB) begin
      w_word = {payload, p};
    end else begin
      w_word = {1'b0, payload} | ((c_MAX_W+1)'(p) << width);
    end
    return w_word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
// skid_buffer : 2-entry output/skid register pair, registered upstream grant
// Rev 1.0
// ============================================================================
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_grant,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_grant
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;

  logic w_accept;
  logic w_out_free;

  assign o_grant    = !r_skid_valid && !rst;
  assign w_accept   = i_valid && o_grant;
  assign w_out_free = !r_out_valid || i_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_accept) begin
      // Skid is empty whenever we accept, so a freed OUT takes the new word directly.
      if (w_out_free) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_data;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= i_data;
      end
    end else if (i_grant) begin
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

endmodule
`default_nettype wire

// File: rtl/parity_encoder.sv
`default_nettype none
// ============================================================================
// parity_encoder : parity-encodes payloads into a skid buffer, counts deliveries
// Rev 1.0
// ============================================================================
module parity_encoder
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter bit EVEN_ODD    = c_EVEN,
  parameter bit PARITY_BIT  = c_LSB,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic                   valid_i,
  input  logic                   corrupt_i,
  output logic                   grant_o,
  output logic [DATA_WIDTH:0]    data_o,
  output logic                   valid_o,
  input  logic                   grant_i,
  output logic [COUNT_WIDTH-1:0] word_count_o,
  output logic [COUNT_WIDTH-1:0] corrupt_count_o
);

  localparam logic [COUNT_WIDTH-1:0] c_ONE = COUNT_WIDTH'(1);

  logic                  w_corrupt;
  logic                  w_parity;
  logic [DATA_WIDTH:0]   w_word;
  logic [DATA_WIDTH+1:0] w_skid_out;
  logic                  w_out_corrupt;
  logic                  w_xfer;

  logic [COUNT_WIDTH-1:0] r_word_count;
  logic [COUNT_WIDTH-1:0] r_corrupt_count;

  // Gating with valid_i keeps an undriven corrupt_i out of the stored flag.
  assign w_corrupt = valid_i && corrupt_i;
  assign w_parity  = calc_parity(c_MAX_W'(data_i), EVEN_ODD) ^ w_corrupt;
  assign w_word    = (DATA_WIDTH+1)'(assemble_word(c_MAX_W'(data_i), w_parity, PARITY_BIT, DATA_WIDTH));

  skid_buffer #(
    .WIDTH (DATA_WIDTH+2)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_data  ({w_corrupt, w_word}),
    .i_valid (valid_i),
    .o_grant (grant_o),
    .o_data  (w_skid_out),
    .o_valid (valid_o),
    .i_grant (grant_i)
  );

  assign data_o        = w_skid_out[DATA_WIDTH:0];
  assign w_out_corrupt = w_skid_out[DATA_WIDTH+1];
  assign w_xfer        = valid_o && grant_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_count    <= '0;
      r_corrupt_count <= '0;
    end else if (w_xfer) begin
      r_word_count <= r_word_count + c_ONE;
      if (w_out_corrupt) begin
        r_corrupt_count <= r_corrupt_count + c_ONE;
      end
    end
  end

  assign word_count_o    = r_word_count;
  assign corrupt_count_o = r_corrupt_count;

endmodule
`default_nettype wire

// File: tb/tb_parity_encoder.sv
`default_nettype none
// ============================================================================
// tb_parity_encoder : scoreboard bench for parity_encoder (8-bit payloads)
// Rev 1.0
// ============================================================================
module tb_parity_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        corrupt_i;
  logic        grant_i;
  logic        grant_o;
  logic [8:0]  data_o;
  logic        valid_o;
  logic [15:0] word_count_o;
  logic [15:0] corrupt_count_o;

  logic        eo_grant_o, pb_grant_o;
  logic [8:0]  eo_data_o, pb_data_o;
  logic        eo_valid_o, pb_valid_o;
  logic [15:0] eo_wc, eo_cc, pb_wc, pb_cc;

  always #5 clk = ~clk;

  parity_encoder #(.DATA_WIDTH(8), .EVEN_ODD(1'b0), .PARITY_BIT(1'b0), .COUNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .corrupt_i(corrupt_i),
    .grant_o(grant_o), .data_o(data_o), .valid_o(valid_o), .grant_i(grant_i),
    .word_count_o(word_count_o), .corrupt_count_o(corrupt_count_o));

  parity_encoder #(.DATA_WIDTH(8), .EVEN_ODD(1'b1), .PARITY_BIT(1'b0), .COUNT_WIDTH(16)) u_dut_odd (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .corrupt_i(corrupt_i),
    .grant_o(eo_grant_o), .data_o(eo_data_o), .valid_o(eo_valid_o), .grant_i(grant_i),
    .word_count_o(eo_wc), .corrupt_count_o(eo_cc));

  parity_encoder #(.DATA_WIDTH(8), .EVEN_ODD(1'b0), .PARITY_BIT(1'b1), .COUNT_WIDTH(16)) u_dut_msb (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .corrupt_i(corrupt_i),
    .grant_o(pb_grant_o), .data_o(pb_data_o), .valid_o(pb_valid_o), .grant_i(grant_i),
    .word_count_o(pb_wc), .corrupt_count_o(pb_cc));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Even parity, parity in bit 0.
  function automatic logic [8:0] model(input logic [7:0] d, input logic c);
    return {d, (^d) ^ c};
  endfunction

  logic [9:0]  exp_q[$];
  logic [15:0] exp_words = '0;
  logic [15:0] exp_corr  = '0;
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_data  = '0;

  always @(negedge clk) begin
    logic [9:0] e;
    chk("grant_o", grant_o, (!rst && exp_q.size() < 2));
    chk("valid_o", valid_o, exp_q.size() > 0);
    chk("word_count", word_count_o, exp_words);
    chk("corrupt_count", corrupt_count_o, exp_corr);
    if (prev_stall && !rst) chk("hold", data_o, prev_data);
    prev_stall = valid_o && !grant_i && !rst;
    prev_data  = data_o;
    if (rst) begin
      exp_q.delete();
      exp_words = '0;
      exp_corr  = '0;
    end else begin
      if (valid_o && grant_i) begin
        if (exp_q.size() == 0) begin
          chk("underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data_o", data_o, e[8:0]);
          exp_words = exp_words + 16'd1;
          if (e[9]) exp_corr = exp_corr + 16'd1;
        end
      end
      if (valid_i && grant_o) exp_q.push_back({corrupt_i, model(data_i, corrupt_i)});
    end
  end

  task automatic send(input logic [7:0] d, input logic c);
    data_i    = d;
    corrupt_i = c;
    valid_i   = 1'b1;
    @(posedge clk); #1;
    valid_i   = 1'b0;
    corrupt_i = 1'b0;
  endtask

  initial begin
    logic [15:0] base;
    int sent;
    int cyc;
    rst = 1'b1; data_i = '0; valid_i = 1'b0; corrupt_i = 1'b0; grant_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_wc", word_count_o, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_grant", grant_o, 1);

    // Basic encodings across the three parameterisations
    grant_i = 1'b1;
    send(8'h03, 1'b0);
    chk("even_03", data_o, 9'h006);
    chk("odd_03", eo_data_o, 9'h007);
    chk("msb_03", pb_data_o, 9'h003);
    @(posedge clk); #1;
    chk("wc_1", word_count_o, 1);
    send(8'h07, 1'b0);
    chk("even_07", data_o, 9'h00F);
    chk("odd_07", eo_data_o, 9'h00E);
    chk("msb_07", pb_data_o, 9'h107);
    send(8'h07, 1'b1);
    chk("corrupt_07", data_o, 9'h00E);
    chk("msb_corrupt_07", pb_data_o, 9'h007);
    @(posedge clk); #1;
    chk("cc_1", corrupt_count_o, 1);
    chk("wc_3", word_count_o, 3);

    // Backpressure fills both entries
    grant_i = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    chk("bp_grant", grant_o, 0);
    chk("bp_data", data_o, 9'h003);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_held", data_o, 9'h003);
    grant_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_second", data_o, 9'h005);
    @(posedge clk); #1;
    chk("bp_grant_back", grant_o, 1);
    chk("bp_empty", valid_o, 0);

    // Streaming, one word per cycle
    base = exp_words;
    for (int i = 0; i < 100; i++) begin
      data_i = 8'(i);
      valid_i = 1'b1;
      @(posedge clk); #1;
      chk("stream_valid", valid_o, 1);
    end
    valid_i = 1'b0;
    @(posedge clk); #1;
    chk("stream_wc", word_count_o, base + 16'd100);

    // Random traffic
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      valid_i   = 1'($urandom_range(0, 1));
      data_i    = 8'($urandom);
      corrupt_i = ($urandom_range(0, 7) == 0);
      grant_i   = 1'($urandom_range(0, 1));
      if (valid_i && grant_o) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_sent", sent, 1000);
    valid_i = 1'b0;
    corrupt_i = 1'b0;
    grant_i = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("drain", exp_q.size(), 0);

    // Reset with both entries occupied
    grant_i = 1'b0;
    send(8'hA5, 1'b0);
    send(8'h5A, 1'b1);
    chk("full_grant", grant_o, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_valid", valid_o, 0);
    chk("rst2_grant", grant_o, 0);
    chk("rst2_wc", word_count_o, 0);
    chk("rst2_cc", corrupt_count_o, 0);
    chk("rst2_data", data_o, 0);
    rst = 1'b0;
    #1;
    chk("rst2_grant_up", grant_o, 1);
    grant_i = 1'b1;
    send(8'h3C, 1'b0);
    chk("post_rst_word", data_o, 9'h078);
    @(posedge clk); #1;
    chk("post_rst_wc", word_count_o, 1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
